md_unit_ctrl: RTL and testbench

//   Sequences the multi-cycle multiply/divide resource in the E stage of the 5-stage MIPS pipeline.

---
 rtl/md_unit_ctrl.sv | 130 +++++++++++++
 tb/tb_md_unit_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_ctrl.sv
// rtl/md_unit_ctrl.sv - E-stage multiply/divide sequencer owning architectural HI/LO
module md_unit_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  md_op_e,
   input  logic [31:0] rs_val_e,
   input  logic [31:0] rt_val_e,
   input  logic        is_md_d,
   output logic        start,
   output logic        busy,
   output logic        stall_md,
   output logic [31:0] rd_data_e
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [3:0]  count;
   logic [31:0] hi, lo;
   logic [31:0] hi_s, lo_s;
   logic        dz_s;

   logic        is_mul, is_div, is_arith, commit;
   logic [63:0] mul_a, mul_b, prod;
   logic        div_sgn, neg_a, neg_b, div_zero;
   logic [31:0] mag_a, mag_b, q_mag, r_mag, quot, rem;
   logic [31:0] res_hi, res_lo;

   // Decode the E-stage op and detect the commit edge of a busy window
   always_comb begin
      is_mul   = (md_op_e == OP_MULT) || (md_op_e == OP_MULTU);
      is_div   = (md_op_e == OP_DIV)  || (md_op_e == OP_DIVU);
      is_arith = is_mul || is_div;
      commit   = (state == BUSY) && (count == 4'd1);
   end

   // Result datapath; signed divide works on magnitudes so -2^31/-1 wraps deterministically
   always_comb begin
      mul_a    = (md_op_e == OP_MULT) ? {{32{rs_val_e[31]}}, rs_val_e} : {32'd0, rs_val_e};
      mul_b    = (md_op_e == OP_MULT) ? {{32{rt_val_e[31]}}, rt_val_e} : {32'd0, rt_val_e};
      prod     = mul_a * mul_b;
      div_sgn  = (md_op_e == OP_DIV);
      neg_a    = div_sgn && rs_val_e[31];
      neg_b    = div_sgn && rt_val_e[31];
      mag_a    = neg_a ? (32'd0 - rs_val_e) : rs_val_e;
      mag_b    = neg_b ? (32'd0 - rt_val_e) : rt_val_e;
      div_zero = (rt_val_e == 32'd0);
      q_mag    = div_zero ? 32'd0 : (mag_a / mag_b);
      r_mag    = div_zero ? 32'd0 : (mag_a % mag_b);
      quot     = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
      rem      = neg_a ? (32'd0 - r_mag) : r_mag;
      res_hi   = is_mul ? prod[63:32] : rem;
      res_lo   = is_mul ? prod[31:0]  : quot;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic: start leaves IDLE, last busy cycle returns to IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (is_arith) state_nxt = BUSY;
         BUSY:    if (count == 4'd1) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: busy follows the state flop, stall holds any md op in D during start/busy
   always_comb begin
      busy      = (state == BUSY);
      start     = is_arith && (state == IDLE);
      stall_md  = is_md_d && (start || busy);
      rd_data_e = 32'd0;
      if (md_op_e == OP_MFHI)      rd_data_e = hi;
      else if (md_op_e == OP_MFLO) rd_data_e = lo;
   end

   // Busy counter and shadow results captured on the start edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= 4'd0;
         hi_s  <= 32'd0;
         lo_s  <= 32'd0;
         dz_s  <= 1'b0;
      end else if (start) begin
         count <= is_mul ? MULT_N : DIV_N;
         hi_s  <= res_hi;
         lo_s  <= res_lo;
         dz_s  <= is_div && div_zero;
      end else if (state == BUSY) begin
         count <= count - 4'd1;
      end
   end

   // Architectural HI/LO: commit has priority; direct moves only when idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi <= 32'd0;
         lo <= 32'd0;
      end else if (commit) begin
         if (!dz_s) begin
            hi <= hi_s;
            lo <= lo_s;
         end
      end else if (state == IDLE) begin
         if (md_op_e == OP_MTHI) hi <= rs_val_e;
         if (md_op_e == OP_MTLO) lo <= rs_val_e;
      end
   end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb/tb_md_unit_ctrl.sv - randomized self-checking bench for md_unit_ctrl
module tb_md_unit_ctrl;

   logic        clk;
   logic        reset;
   logic [3:0]  md_op_e;
   logic [31:0] rs_val_e;
   logic [31:0] rt_val_e;
   logic        is_md_d;
   logic        start;
   logic        busy;
   logic        stall_md;
   logic [31:0] rd_data_e;

   int pass_cnt = 0;
   int total_cnt = 0;
   logic [31:0] hi_m = 32'd0;
   logic [31:0] lo_m = 32'd0;

   md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .md_op_e(md_op_e), .rs_val_e(rs_val_e),
      .rt_val_e(rt_val_e), .is_md_d(is_md_d), .start(start), .busy(busy),
      .stall_md(stall_md), .rd_data_e(rd_data_e)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic int lat(input logic [3:0] op);
      return (op <= 4'd2) ? 5 : 10;
   endfunction

   // Reference: architectural effect of an md op computed with 64-bit integer math
   function automatic void model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      logic [63:0] v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      case (op)
         4'd1: begin v = sa * sb; hi_m = v[63:32]; lo_m = v[31:0]; end
         4'd2: begin v = ua * ub; hi_m = v[63:32]; lo_m = v[31:0]; end
         4'd3: if (b != 0) begin
            q = sa / sb; r = sa % sb;
            v = q; lo_m = v[31:0];
            v = r; hi_m = v[31:0];
         end
         4'd4: if (b != 0) begin
            uq = ua / ub; ur = ua % ub;
            v = uq; lo_m = v[31:0];
            v = ur; hi_m = v[31:0];
         end
         4'd7: hi_m = a;
         4'd8: lo_m = a;
         default: ;
      endcase
   endfunction

   task automatic peek(input logic [3:0] op, output logic [31:0] v);
      md_op_e = op;
      #1;
      v = rd_data_e;
      md_op_e = 4'd0;
      #1;
   endtask

   task automatic do_move(input logic [3:0] op, input logic [31:0] val);
      md_op_e = op;
      rs_val_e = val;
      cyc();
      md_op_e = 4'd0;
      model_exec(op, val, 32'd0);
   endtask

   // Issue one arithmetic op in the current cycle and ride out its busy window
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic md, output logic st, output int nb, output logic stall_ok);
      md_op_e = op; rs_val_e = a; rt_val_e = b; is_md_d = md;
      #1;
      st = start;
      stall_ok = (stall_md === md);
      nb = 0;
      cyc();
      md_op_e = 4'd0;
      #1;
      while (busy === 1'b1 && nb < 20) begin
         if (stall_md !== md) stall_ok = 1'b0;
         nb++;
         cyc();
      end
      if (stall_md !== 1'b0) stall_ok = 1'b0;
      is_md_d = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else pass_cnt++;
      md_op_e = 4'd9; #1;
      total_cnt++; if (start !== 1'b0) $display("FAIL reset_op9_start got=%0b exp=0", start); else pass_cnt++;
      md_op_e = 4'd0;
      peek(4'd5, v);
      total_cnt++; if (v !== 32'd0) $display("FAIL reset_hi got=%h exp=0", v); else pass_cnt++;
      peek(4'd6, v);
      total_cnt++; if (v !== 32'd0) $display("FAIL reset_lo got=%h exp=0", v); else pass_cnt++;
   endtask

   task automatic test_mult_directed();
      logic st, sok; int nb; logic [31:0] v;
      run_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, st, nb, sok);
      total_cnt++; if (st !== 1'b1) $display("FAIL mult_start got=%0b exp=1", st); else pass_cnt++;
      total_cnt++; if (nb != 5) $display("FAIL mult_busy_len got=%0d exp=5", nb); else pass_cnt++;
      peek(4'd5, v);
      total_cnt++; if (v !== 32'hFFFFFFFF) $display("FAIL mult_hi got=%h exp=ffffffff", v); else pass_cnt++;
      peek(4'd6, v);
      total_cnt++; if (v !== 32'hFFFFFFFA) $display("FAIL mult_lo got=%h exp=fffffffa", v); else pass_cnt++;
      model_exec(4'd1, 32'hFFFFFFFE, 32'd3);
   endtask

   task automatic test_div_directed();
      logic st, sok; int nb; logic [31:0] v;
      run_op(4'd4, 32'd100, 32'd7, 1'b0, st, nb, sok);
      total_cnt++; if (nb != 10) $display("FAIL divu_busy_len got=%0d exp=10", nb); else pass_cnt++;
      peek(4'd5, v);
      total_cnt++; if (v !== 32'd2) $display("FAIL divu_hi got=%h exp=2", v); else pass_cnt++;
      peek(4'd6, v);
      total_cnt++; if (v !== 32'd14) $display("FAIL divu_lo got=%h exp=e", v); else pass_cnt++;
      run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, st, nb, sok);
      peek(4'd5, v);
      total_cnt++; if (v !== 32'hFFFFFFFF) $display("FAIL div_hi got=%h exp=ffffffff", v); else pass_cnt++;
      peek(4'd6, v);
      total_cnt++; if (v !== 32'hFFFFFFFD) $display("FAIL div_lo got=%h exp=fffffffd", v); else pass_cnt++;
      model_exec(4'd3, 32'hFFFFFFF9, 32'd2);
   endtask

   task automatic test_random_arith();
      logic st, sok; int nb; logic [31:0] a, b, v; logic [3:0] op;
      for (int i = 0; i < 16; i++) begin
         op = 4'($urandom_range(1, 4));
         a = $urandom;
         b = $urandom;
         if (i == 3) begin op = 4'd3; a = 32'h80000000; b = 32'hFFFFFFFF; end
         if (i == 5) b = 32'd1;
         run_op(op, a, b, 1'b0, st, nb, sok);
         model_exec(op, a, b);
         total_cnt++; if (st !== 1'b1 || nb != lat(op)) $display("FAIL rand%0d_timing op=%0d start=%0b busy_len=%0d exp_len=%0d", i, op, st, nb, lat(op)); else pass_cnt++;
         peek(4'd5, v);
         total_cnt++; if (v !== hi_m) $display("FAIL rand%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, v, hi_m); else pass_cnt++;
         peek(4'd6, v);
         total_cnt++; if (v !== lo_m) $display("FAIL rand%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, v, lo_m); else pass_cnt++;
      end
   endtask

   task automatic test_stall();
      logic st, sok; int nb; logic [31:0] a, b;
      a = $urandom; b = $urandom;
      run_op(4'd2, a, b, 1'b1, st, nb, sok);
      model_exec(4'd2, a, b);
      total_cnt++; if (sok !== 1'b1) $display("FAIL stall_md_high got_ok=%0b exp_ok=1", sok); else pass_cnt++;
      a = $urandom; b = $urandom | 32'd1;
      run_op(4'd4, a, b, 1'b0, st, nb, sok);
      model_exec(4'd4, a, b);
      total_cnt++; if (sok !== 1'b1) $display("FAIL stall_md_low got_ok=%0b exp_ok=1", sok); else pass_cnt++;
   endtask

   task automatic test_div_zero();
      logic [31:0] v; int nb;
      do_move(4'd7, 32'h11);
      do_move(4'd8, 32'h22);
      md_op_e = 4'd3; rs_val_e = 32'd5; rt_val_e = 32'd0;
      cyc();
      md_op_e = 4'd0;
      peek(4'd5, v);
      total_cnt++; if (v !== 32'h11) $display("FAIL dz_mfhi_busy got=%h exp=11", v); else pass_cnt++;
      nb = 0;
      while (busy === 1'b1 && nb < 20) begin nb++; cyc(); end
      total_cnt++; if (nb != 10) $display("FAIL dz_busy_len got=%0d exp=10", nb); else pass_cnt++;
      peek(4'd5, v);
      total_cnt++; if (v !== 32'h11) $display("FAIL dz_hi got=%h exp=11", v); else pass_cnt++;
      peek(4'd6, v);
      total_cnt++; if (v !== 32'h22) $display("FAIL dz_lo got=%h exp=22", v); else pass_cnt++;
   endtask

   task automatic test_busy_ignore();
      logic [31:0] a, b, v, old_lo; int nb;
      a = $urandom; b = $urandom;
      old_lo = lo_m;
      md_op_e = 4'd1; rs_val_e = a; rt_val_e = b;
      cyc();
      md_op_e = 4'd7; rs_val_e = $urandom;
      #1;
      total_cnt++; if (start !== 1'b0) $display("FAIL busy_mthi_start got=%0b exp=0", start); else pass_cnt++;
      cyc();
      md_op_e = 4'd3; rt_val_e = 32'd3;
      #1;
      total_cnt++; if (start !== 1'b0) $display("FAIL busy_div_start got=%0b exp=0", start); else pass_cnt++;
      cyc();
      md_op_e = 4'd0;
      peek(4'd6, v);
      total_cnt++; if (v !== old_lo) $display("FAIL busy_mflo_precommit got=%h exp=%h", v, old_lo); else pass_cnt++;
      nb = 2;
      while (busy === 1'b1 && nb < 20) begin nb++; cyc(); end
      total_cnt++; if (nb != 5) $display("FAIL busy_ignore_len got=%0d exp=5", nb); else pass_cnt++;
      model_exec(4'd1, a, b);
      peek(4'd5, v);
      total_cnt++; if (v !== hi_m) $display("FAIL busy_ignore_hi got=%h exp=%h", v, hi_m); else pass_cnt++;
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] v; logic quiet;
      do_move(4'd7, $urandom | 32'd1);
      do_move(4'd8, $urandom | 32'd1);
      md_op_e = 4'd1; rs_val_e = $urandom | 32'd1; rt_val_e = $urandom | 32'd1;
      cyc();
      md_op_e = 4'd0;
      cyc();
      cyc();
      #2;
      reset = 1'b1;
      #1;
      hi_m = 32'd0; lo_m = 32'd0;
      total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%0b exp=0", busy); else pass_cnt++;
      peek(4'd5, v);
      total_cnt++; if (v !== 32'd0) $display("FAIL rst_mid_hi got=%h exp=0", v); else pass_cnt++;
      peek(4'd6, v);
      total_cnt++; if (v !== 32'd0) $display("FAIL rst_mid_lo got=%h exp=0", v); else pass_cnt++;
      cyc();
      cyc();
      reset = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (busy !== 1'b0) quiet = 1'b0;
         cyc();
      end
      total_cnt++; if (quiet !== 1'b1) $display("FAIL rst_mid_no_busy got=%0b exp=1", quiet); else pass_cnt++;
      peek(4'd6, v);
      total_cnt++; if (v !== 32'd0) $display("FAIL rst_mid_no_commit got=%h exp=0", v); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic st1, st2, sok; int nb1, nb2; logic [31:0] a, b, c, d, v;
      a = $urandom; b = $urandom; c = $urandom; d = $urandom;
      run_op(4'd1, a, b, 1'b0, st1, nb1, sok);
      model_exec(4'd1, a, b);
      run_op(4'd1, c, d, 1'b0, st2, nb2, sok);
      model_exec(4'd1, c, d);
      total_cnt++; if (st2 !== 1'b1) $display("FAIL b2b_start got=%0b exp=1", st2); else pass_cnt++;
      total_cnt++; if (nb1 + nb2 != 10) $display("FAIL b2b_len got=%0d exp=10", nb1 + nb2); else pass_cnt++;
      peek(4'd6, v);
      total_cnt++; if (v !== lo_m) $display("FAIL b2b_lo got=%h exp=%h", v, lo_m); else pass_cnt++;
      peek(4'd5, v);
      total_cnt++; if (v !== hi_m) $display("FAIL b2b_hi got=%h exp=%h", v, hi_m); else pass_cnt++;
   endtask

   initial begin
      reset = 1'b1;
      md_op_e = 4'd0;
      rs_val_e = 32'd0;
      rt_val_e = 32'd0;
      is_md_d = 1'b0;
      cyc();
      test_reset();
      cyc();
      reset = 1'b0;
      cyc();
      test_mult_directed();
      test_div_directed();
      test_random_arith();
      test_stall();
      test_div_zero();
      test_busy_ignore();
      test_reset_mid_op();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
